// File: rtl/tim_apb_pkg.sv
// Shared types and constants for the timer-subsystem APB initiators.
// State encoding, protection masks and watchdog defaults.
package tim_apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  localparam logic [2:0] APB_PROT_SECURE = 3'b010;

  localparam int TIM_TIMEOUT_DEF = 255;
  localparam int TIM_CNT_W_DEF   = 8;

endpackage

// File: rtl/apb_tim_wdog.sv
// APB access-phase watchdog: counts stalled cycles, flags expiry.
// A TIMEOUT of 0 disables expiry entirely.
module apb_tim_wdog
  import tim_apb_pkg::*;
#(
  parameter int TIMEOUT = TIM_TIMEOUT_DEF,
  parameter int CNT_W   = TIM_CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST =
    (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;
  logic             armed;

  assign armed  = (TIMEOUT != 0);
  assign expire = armed && en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && !expire) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/apb_tim_master.sv
// APB3 initiator: valid/ready request/response to SETUP/ACCESS phases.
// Includes wait-state handling, a watchdog and a misalignment check.
module apb_tim_master
  import tim_apb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIM_TIMEOUT_DEF,
  parameter int CNT_W   = TIM_CNT_W_DEF
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [2:0]        req_prot,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic [ADDR_W-1:0] paddr,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  output logic [2:0]        pprot,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  apb_state_e state, state_nx;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              write_q;
  logic [2:0]        prot_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              tmo_q;

  logic accept;
  logic misalign;
  logic expire;
  logic wd_clr;
  logic wd_en;

  assign accept   = (state == ST_IDLE) && req_valid;
  assign misalign = (req_addr[1:0] != 2'b00);
  assign wd_clr   = (state == ST_SETUP);
  assign wd_en    = (state == ST_ACCESS) && !pready;

  apb_tim_wdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wdog (
    .clk    (pclk),
    .rst    (preset),
    .clr    (wd_clr),
    .en     (wd_en),
    .expire (expire)
  );

  always_ff @(posedge pclk) begin
    if (preset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (req_valid) begin
          state_nx = misalign ? ST_RESP : ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_nx = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready || expire) begin
          state_nx = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_nx = ST_IDLE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Request fields are latched once and drive the bus for the whole transfer.
  always_ff @(posedge pclk) begin
    if (preset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      prot_q  <= 3'b000;
    end else if (accept) begin
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      write_q <= req_write;
      prot_q  <= req_prot;
    end
  end

  // Response fields only change on entry to RESP; pready beats the watchdog.
  always_ff @(posedge pclk) begin
    if (preset) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      unique case (1'b1)
        accept && misalign: begin
          rdata_q <= '0;
          err_q   <= 1'b1;
          tmo_q   <= 1'b0;
        end
        (state == ST_ACCESS) && pready: begin
          rdata_q <= (!write_q && !pslverr) ? prdata : '0;
          err_q   <= pslverr;
          tmo_q   <= 1'b0;
        end
        (state == ST_ACCESS) && expire: begin
          rdata_q <= '0;
          err_q   <= 1'b1;
          tmo_q   <= 1'b1;
        end
        default: begin
          rdata_q <= rdata_q;
          err_q   <= err_q;
          tmo_q   <= tmo_q;
        end
      endcase
    end
  end

  assign req_ready   = (state == ST_IDLE);
  assign rsp_valid   = (state == ST_RESP);
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign rsp_timeout = tmo_q;

  assign psel    = (state == ST_SETUP) || (state == ST_ACCESS);
  assign penable = (state == ST_ACCESS);
  assign paddr   = addr_q;
  assign pwrite  = write_q;
  assign pwdata  = wdata_q;
  assign pprot   = prot_q;

endmodule

// File: doc/apb_tim_master.md
Name: apb_tim_master

Overview:
- APB3 initiator for the timer subsystem: the requester side of the peripheral bus that the timer slaves respond on.
- Converts a single-outstanding valid/ready request channel from a local controller (ETB-side sequencer or test controller) into APB SETUP/ACCESS phases.
- Returns read data and error status on a valid/ready response channel.
- Adds pready wait-state support, a bus-timeout watchdog and a misaligned-address check, so a hung or absent slave cannot stall the controller.

Parameters:
- ADDR_W, 32, width of req_addr/paddr
- DATA_W, 32, width of wdata/rdata
- TIMEOUT, 255, maximum ACCESS-phase cycles waiting for pready before abort; 0 disables the watchdog
- CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT

Ports:
- pclk  in  1  bus clock; all logic is on the rising edge
- preset  in  1  synchronous reset, active-high
- req_valid  in  1  request offered
- req_ready  out  1  request accepted when req_valid && req_ready
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  write data
- req_prot  in  3  APB protection attributes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_rdata  out  DATA_W  read data; 0 for writes and errored transfers
- rsp_err  out  1  pslverr, timeout or misalignment
- rsp_timeout  out  1  error was caused by the watchdog
- psel  out  1  APB select
- penable  out  1  APB enable
- paddr  out  ADDR_W  APB address
- pwrite  out  1  APB direction
- pwdata  out  DATA_W  APB write data
- pprot  out  3  APB protection
- prdata  in  DATA_W  APB read data
- pready  in  1  APB ready; tie to 1 for zero-wait slaves
- pslverr  in  1  APB error; tie to 0 if the slave does not drive it

Behaviour:
- Reset and clock:
  - Synchronous: preset=1 sampled on a pclk edge puts the block in IDLE.
  - Reset values are 0 on every output except req_ready, which resets to 1.
- State machine, states IDLE, SETUP, ACCESS, RESP; registered outputs only:
  - req_ready = (state==IDLE).
  - rsp_valid = (state==RESP).
- IDLE, on a handshake:
  - Register addr, wdata, write and prot.
  - If req_addr[1:0] != 0: go straight to RESP with rsp_err=1, rsp_timeout=0, rsp_rdata=0. No APB activity.
  - Otherwise: go to SETUP.
- SETUP: psel=1, penable=0, paddr/pwrite/pwdata/pprot driven from the registers. Unconditionally go to ACCESS next cycle.
- ACCESS: psel=1, penable=1. All APB outputs are held stable until exit.
  - pready=1: capture rsp_err=pslverr. Set rsp_rdata=prdata for reads with pslverr=0, else 0. Go to RESP. psel and penable drop on the same edge.
  - pready=0: timeout counter increments; it is cleared on entry to SETUP.
  - Counter==TIMEOUT-1 with pready=0 (TIMEOUT!=0): abort to RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0. psel and penable drop.
  - pready and timeout in the same cycle: pready wins and the transfer completes normally.
- RESP:
  - Hold rsp_valid and all rsp_* outputs stable until rsp_ready, then go to IDLE.
  - rsp_valid and rsp_ready together in RESP: IDLE next cycle; the next request is accepted no earlier than that cycle.
- Latency:
  - Handshake at cycle 0, SETUP at cycle 1, ACCESS at cycle 2.
  - pready=1 at cycle 2 gives rsp_valid at cycle 3.
  - Each wait state adds 1 cycle.
  - Peak throughput: 1 transfer per 4 cycles with rsp_ready held at 1.
- Invariants:
  - At most one outstanding transfer.
  - penable=1 implies psel=1.
  - No glitch cycle between back-to-back transfers: psel drops for at least the IDLE cycle.
- Reset mid-transfer: the transfer is dropped with no response. psel and penable are 0 on the cycle after reset is sampled.

Decomposition:
- Shared package (tim_apb_pkg):
  - state encoding (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2, RESP=2'd3)
  - APB_PROT_SECURE mask = 3'b010, used by callers that derive pprot from the trust signals
  - default TIMEOUT constant
- Sub-module: apb_tim_wdog, the timeout counter with clear, enable and expire. It is small but reused by other APB masters in the SoC.

Test Plan:
- Write with pready=1: req addr 0x0000_0004, wdata 0xDEAD_BEEF, prot 3'b010 -> psel at cycle 1; penable at cycle 2 with paddr, pwdata and pprot stable; rsp_valid at cycle 3 with err=0 and rdata=0.
- Read with 3 wait states: prdata=0x1234_5678 arrives with pready on the 4th ACCESS cycle -> rsp_rdata=0x1234_5678 and rsp_valid at cycle 6; APB signals unchanged during the waits.
- Error: pslverr=1 with pready -> rsp_err=1, rsp_timeout=0, rsp_rdata=0. Misaligned addr 0x0000_0002 -> rsp_err=1 at cycle 1 and psel never asserts.
- Timeout: TIMEOUT=4, pready stuck at 0 -> abort after 4 ACCESS cycles; rsp_err=1, rsp_timeout=1, psel=0. Then a new request completes normally.
- Backpressure and reset:
  - rsp_ready=0 for 5 cycles -> rsp_* held stable and req_ready=0 throughout.
  - preset=1 during ACCESS -> next cycle psel=0, penable=0, rsp_valid=0 and req_ready=1.
